// File: rtl/mont_exp_ctrl.sv
// Montgomery modular exponentiation sequencer: drives one external Montgomery
// multiplier through to-Montgomery, left-to-right square-and-multiply and
// from-Montgomery steps to produce result = x^e mod m.
module mont_exp_ctrl #(
    parameter int unsigned N     = 512,
    parameter int unsigned E_W   = 512,
    parameter int unsigned LEN_W = 10,
    parameter int unsigned CNT_W = 11
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [N-1:0]     in_x,
    input  logic [E_W-1:0]   in_e,
    input  logic [LEN_W-1:0] in_elen,
    input  logic [N-1:0]     in_m,
    input  logic [N-1:0]     in_r,
    input  logic [N-1:0]     in_r2,
    output logic             busy,
    output logic             done,
    output logic [N-1:0]     result,
    output logic [CNT_W-1:0] mm_count,
    output logic             mm_start,
    output logic [N-1:0]     mm_a,
    output logic [N-1:0]     mm_b,
    output logic [N-1:0]     mm_m,
    input  logic             mm_done,
    input  logic [N-1:0]     mm_result
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_TOMONT,
        S_SQ,
        S_MUL,
        S_FROMMONT,
        S_DONE
    } state_t;

    state_t           state_q, state_d;
    logic [N-1:0]     x_q, r2_q, acc_q, xt_q;
    logic [N-1:0]     acc_d, xt_d, op_a_d, op_b_d;
    logic [E_W-1:0]   e_q;
    logic [LEN_W-1:0] len_q, idx_q, idx_d, len_clamp;
    logic             go_q;
    logic             mm_start_q, busy_q, done_q;
    logic [N-1:0]     mm_a_q, mm_b_q, mm_m_q, result_q;
    logic [CNT_W-1:0] mm_count_q;
    logic             e_bit;

    // Exponent lengths beyond the register width are capped
    assign len_clamp = (in_elen > LEN_W'(E_W)) ? LEN_W'(E_W) : in_elen;
    assign e_bit     = |(e_q & (E_W'(1) << idx_q));

    // Decision taken when the multiplier reports completion: next step and its operands
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        acc_d   = acc_q;
        xt_d    = xt_q;
        op_a_d  = '0;
        op_b_d  = '0;
        case (state_q)
            S_TOMONT: begin
                xt_d    = mm_result;
                state_d = (len_q != '0) ? S_SQ : S_FROMMONT;
            end
            S_SQ: begin
                acc_d = mm_result;
                if (e_bit) begin
                    state_d = S_MUL;
                end else if (idx_q == '0) begin
                    state_d = S_FROMMONT;
                end else begin
                    idx_d   = idx_q - LEN_W'(1);
                    state_d = S_SQ;
                end
            end
            S_MUL: begin
                acc_d = mm_result;
                if (idx_q == '0) begin
                    state_d = S_FROMMONT;
                end else begin
                    idx_d   = idx_q - LEN_W'(1);
                    state_d = S_SQ;
                end
            end
            S_FROMMONT: state_d = S_DONE;
            default: ;
        endcase
        case (state_d)
            S_SQ: begin
                op_a_d = acc_d;
                op_b_d = acc_d;
            end
            S_MUL: begin
                op_a_d = acc_d;
                op_b_d = xt_d;
            end
            S_FROMMONT: begin
                op_a_d = acc_d;
                op_b_d = N'(1);
            end
            default: ;
        endcase
    end

    // Sequencer FSM: issue/wait handshake per multiplication, registered outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            x_q        <= '0;
            e_q        <= '0;
            r2_q       <= '0;
            len_q      <= '0;
            idx_q      <= '0;
            acc_q      <= '0;
            xt_q       <= '0;
            go_q       <= 1'b0;
            mm_start_q <= 1'b0;
            mm_a_q     <= '0;
            mm_b_q     <= '0;
            mm_m_q     <= '0;
            mm_count_q <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            result_q   <= '0;
        end else begin
            done_q     <= 1'b0;
            mm_start_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        x_q        <= in_x;
                        e_q        <= in_e;
                        r2_q       <= in_r2;
                        mm_m_q     <= in_m;
                        len_q      <= len_clamp;
                        idx_q      <= len_clamp - LEN_W'(1);
                        acc_q      <= in_r;
                        mm_count_q <= '0;
                        busy_q     <= 1'b1;
                        go_q       <= 1'b1;
                        state_q    <= S_TOMONT;
                    end
                end
                S_DONE: begin
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: begin
                    if (go_q) begin
                        // first multiplication of an operation: convert x into the Montgomery domain
                        go_q       <= 1'b0;
                        mm_start_q <= 1'b1;
                        mm_a_q     <= x_q;
                        mm_b_q     <= r2_q;
                        mm_count_q <= mm_count_q + CNT_W'(1);
                    end else if (!mm_start_q && mm_done) begin
                        // completion in WAIT: capture and issue the next step back to back
                        acc_q   <= acc_d;
                        xt_q    <= xt_d;
                        idx_q   <= idx_d;
                        state_q <= state_d;
                        if (state_d == S_DONE) begin
                            result_q <= mm_result;
                            done_q   <= 1'b1;
                        end else begin
                            mm_start_q <= 1'b1;
                            mm_a_q     <= op_a_d;
                            mm_b_q     <= op_b_d;
                            mm_count_q <= mm_count_q + CNT_W'(1);
                        end
                    end
                end
            endcase
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign result   = result_q;
    assign mm_count = mm_count_q;
    assign mm_start = mm_start_q;
    assign mm_a     = mm_a_q;
    assign mm_b     = mm_b_q;
    assign mm_m     = mm_m_q;

endmodule

// File: tb/tb_mont_exp_ctrl.sv
// Bench for mont_exp_ctrl: behavioural Montgomery multiplier with configurable
// latency, golden modular exponentiation by plain arithmetic.
module tb_mont_exp_ctrl;

    localparam int unsigned N     = 512;
    localparam int unsigned E_W   = 512;
    localparam int unsigned LEN_W = 10;
    localparam int unsigned CNT_W = 11;
    localparam int unsigned W2    = 2 * N + 1;
    localparam int          BOUND = 30000;

    logic             clk, reset, start;
    logic [N-1:0]     in_x, in_m, in_r, in_r2;
    logic [E_W-1:0]   in_e;
    logic [LEN_W-1:0] in_elen;
    logic             busy, done, mm_start;
    logic [N-1:0]     result, mm_a, mm_b, mm_m;
    logic [CNT_W-1:0] mm_count;
    logic             mm_done_m, spur, mm_done_w;
    logic [N-1:0]     mm_res_m, mm_result_w;

    int               checks, failures, lat_g;
    logic [N-1:0]     cur_m;

    assign mm_done_w   = mm_done_m | spur;
    assign mm_result_w = spur ? {N{1'b1}} : mm_res_m;

    mont_exp_ctrl #(.N(N), .E_W(E_W), .LEN_W(LEN_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset), .start(start),
        .in_x(in_x), .in_e(in_e), .in_elen(in_elen), .in_m(in_m),
        .in_r(in_r), .in_r2(in_r2),
        .busy(busy), .done(done), .result(result), .mm_count(mm_count),
        .mm_start(mm_start), .mm_a(mm_a), .mm_b(mm_b), .mm_m(mm_m),
        .mm_done(mm_done_w), .mm_result(mm_result_w)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // a*b*2^-N mod m by bit-serial reduction
    function automatic logic [N-1:0] mont(input logic [N-1:0] a, input logic [N-1:0] b,
                                          input logic [N-1:0] m);
        logic [W2-1:0] t;
        t = W2'(a) * W2'(b);
        for (int i = 0; i < int'(N); i++) begin
            if (t[0]) t = t + W2'(m);
            t = t >> 1;
        end
        if (t >= W2'(m)) t = t - W2'(m);
        return t[N-1:0];
    endfunction

    function automatic logic [N-1:0] pow2mod(input int k, input logic [N-1:0] m);
        logic [W2-1:0] p;
        p = W2'(1) << k;
        p = p % W2'(m);
        return p[N-1:0];
    endfunction

    // x^e mod m over the low len exponent bits, ordinary modular arithmetic
    function automatic logic [N-1:0] modexp(input logic [N-1:0] x, input logic [E_W-1:0] e,
                                            input int len, input logic [N-1:0] m);
        logic [2*N-1:0] acc, mm, xx;
        mm  = {{N{1'b0}}, m};
        xx  = {{N{1'b0}}, x};
        acc = 1;
        acc = acc % mm;
        for (int i = len - 1; i >= 0; i--) begin
            acc = (acc * acc) % mm;
            if (e[i]) acc = (acc * xx) % mm;
        end
        return acc[N-1:0];
    endfunction

    function automatic logic [N-1:0] rand_n();
        logic [N-1:0] v;
        for (int i = 0; i < int'(N / 32); i++) v[32*i +: 32] = $urandom;
        return v;
    endfunction

    task automatic chk(input string name, input logic [N-1:0] act, input logic [N-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic chk_zero(input string name);
        chk({name, "_busy"},     N'(busy),     N'(0));
        chk({name, "_done"},     N'(done),     N'(0));
        chk({name, "_mm_start"}, N'(mm_start), N'(0));
        chk({name, "_result"},   result,       N'(0));
        chk({name, "_mm_a"},     mm_a,         N'(0));
        chk({name, "_mm_b"},     mm_b,         N'(0));
        chk({name, "_mm_m"},     mm_m,         N'(0));
        chk({name, "_mm_count"}, N'(mm_count), N'(0));
    endtask

    // Behavioural multiplier: captures on mm_start, answers L cycles later, checks operand stability
    initial begin
        logic [N-1:0] ca, cb, cm, res;
        int           cnt;
        bit           pend;
        mm_done_m = 1'b0;
        mm_res_m  = '0;
        pend      = 1'b0;
        cnt       = 0;
        ca = '0; cb = '0; cm = '0; res = '0;
        forever begin
            @(negedge clk);
            mm_done_m = 1'b0;
            if (reset) begin
                pend = 1'b0;
            end else if (pend) begin
                checks++;
                if (mm_a !== ca || mm_b !== cb || mm_m !== cm || mm_start !== 1'b0) begin
                    failures++;
                    $display("FAIL wait_stable actual a=%0h b=%0h start=%0b required a=%0h b=%0h start=0",
                             mm_a, mm_b, mm_start, ca, cb);
                end
                cnt--;
                if (cnt == 0) begin
                    mm_done_m = 1'b1;
                    mm_res_m  = res;
                    pend      = 1'b0;
                end
            end else if (mm_start === 1'b1) begin
                ca = mm_a;
                cb = mm_b;
                cm = mm_m;
                chk("mm_m", mm_m, cur_m);
                res  = mont(ca, cb, cm);
                cnt  = (lat_g == 0) ? int'($urandom_range(1, 20)) : lat_g;
                pend = 1'b1;
            end
        end
    end

    task automatic run_op(input logic [N-1:0] x, input logic [E_W-1:0] e, input int elen,
                          input logic [N-1:0] m, input int lat, input bit inject,
                          input bit chk_cyc, input string name);
        int           len, exp_cnt, cyc, nspur;
        bit           got, busy_bad;
        logic [N-1:0] exp_res;
        len     = (elen > int'(E_W)) ? int'(E_W) : elen;
        exp_res = modexp(x, e, len, m);
        exp_cnt = 2 + len;
        for (int i = 0; i < len; i++) exp_cnt += int'(e[i]);
        lat_g   = lat;
        cur_m   = m;
        in_x    = x;
        in_e    = e;
        in_elen = LEN_W'(elen);
        in_m    = m;
        in_r    = pow2mod(N, m);
        in_r2   = pow2mod(2 * N, m);
        if (inject) begin
            spur = 1'b1;
            @(negedge clk);
            spur = 1'b0;
        end
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        in_x  = ~x;
        in_e  = ~e;
        in_m  = rand_n();
        in_r  = rand_n();
        in_r2 = rand_n();
        cyc = 1; got = 1'b0; busy_bad = 1'b0; nspur = 0;
        while (cyc < BOUND) begin
            if (done === 1'b1) begin
                got = 1'b1;
                break;
            end
            if (busy !== 1'b1) busy_bad = 1'b1;
            if (inject && cyc == 10) start = 1'b1;
            if (inject && mm_start === 1'b1 && nspur < 2) begin
                spur = 1'b1;
                nspur++;
            end
            @(negedge clk);
            start = 1'b0;
            spur  = 1'b0;
            cyc++;
        end
        chk({name, "_finished"}, N'(got), N'(1));
        if (got) begin
            chk({name, "_result"},   result,       exp_res);
            chk({name, "_mm_count"}, N'(mm_count), N'(exp_cnt));
            chk({name, "_busy_done"}, N'(busy),    N'(1));
            chk({name, "_busy_held"}, N'(busy_bad), N'(0));
            if (chk_cyc) chk({name, "_cycles"}, N'(cyc), N'(2 + exp_cnt * (lat + 1)));
        end
        @(negedge clk);
        chk({name, "_post_busy"}, N'(busy), N'(0));
        chk({name, "_post_done"}, N'(done), N'(0));
    endtask

    initial begin
        logic [E_W-1:0] e_hi;
        logic [N-1:0]   rm, rx;
        int             n, cyc;
        checks = 0; failures = 0;
        reset = 1'b1; start = 1'b0; spur = 1'b0;
        in_x = '0; in_e = '0; in_elen = '0; in_m = '0; in_r = '0; in_r2 = '0;
        lat_g = 4; cur_m = '0;
        repeat (3) @(negedge clk);
        chk_zero("reset");
        reset = 1'b0;
        @(negedge clk);

        // model pins: 2^512 mod 13 = 9, 2^1024 mod 13 = 3, mont(R,R) = R, 7^11 mod 13 = 2, 2^5 mod 13 = 6
        chk("pin_r",      pow2mod(N, 13),      N'(9));
        chk("pin_r2",     pow2mod(2 * N, 13),  N'(3));
        chk("pin_mont",   mont(9, 9, 13),      N'(9));
        chk("pin_exp711", modexp(7, 11, 4, 13), N'(2));
        chk("pin_exp25",  modexp(2, 5, 3, 13),  N'(6));

        run_op(2, 5, 3, 13, 4, 1'b0, 1'b1, "t1");
        chk("t1_lit_result", result, N'(6));
        chk("t1_lit_count",  N'(mm_count), N'(7));
        run_op(2, 5, 0, 13, 4, 1'b0, 1'b1, "t2_len0");
        chk("t2_lit_result", result, N'(1));
        run_op(7, 11, 4, 13, 4, 1'b0, 1'b1, "t3");
        chk("t3_lit_count", N'(mm_count), N'(9));
        e_hi    = '1;
        e_hi[2] = 1'b0;
        run_op(7, e_hi, 4, 13, 4, 1'b0, 1'b1, "t3_hibits");
        chk("t3_hibits_lit", result, N'(2));
        run_op(2, 5, 3, 13, 4, 1'b1, 1'b1, "t4_inject");

        // reset during the WAIT of the third multiplication
        lat_g = 4; cur_m = 13;
        in_x = 2; in_e = 5; in_elen = 3; in_m = 13; in_r = 9; in_r2 = 3;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n = 0; cyc = 0;
        while (cyc < 200) begin
            if (mm_start === 1'b1) n++;
            if (n == 3) break;
            @(negedge clk);
            cyc++;
        end
        chk("t5_third_issue", N'(n), N'(3));
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk_zero("t5_midreset");
        reset = 1'b0;
        @(negedge clk);
        run_op(7, 11, 4, 13, 0, 1'b0, 1'b0, "t5_after");

        // full-width random operands
        for (int k = 0; k < 3; k++) begin
            rm = rand_n();
            rm[N-1] = 1'b1;
            rm[0]   = 1'b1;
            rx = rand_n() % rm;
            run_op(rx, rand_n(), (k == 2) ? 700 : 512, rm, 0, 1'b0, 1'b0,
                   (k == 2) ? "rnd_clamp" : "rnd");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mont_exp_ctrl.md
Name: mont_exp_ctrl

Overview:
Sequencer for one external Montgomery multiplier (start/done handshake, operands a, b, m). It computes result = x^e mod m by left-to-right square-and-multiply entirely in the Montgomery domain. It issues the to-Montgomery conversion, the square and multiply steps, and the final from-Montgomery conversion. It sits between the RSA top-level/command interface and the multiplier.

Parameters:
N, 512, operand/modulus width (R = 2^N)
E_W, 512, maximum exponent width
LEN_W, 10, width of exponent-length field (must hold E_W)
CNT_W, 11, width of multiplication counter

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
start  in  1  one-cycle request; sampled only in IDLE
in_x  in  N  base, normal domain, < m
in_e  in  E_W  exponent; bit 0 = LSB
in_elen  in  LEN_W  number of exponent bits to process (values > E_W treated as E_W)
in_m  in  N  odd modulus
in_r  in  N  R mod m
in_r2  in  N  R^2 mod m
busy  out  1  high from accepted start until done pulse inclusive
done  out  1  one-cycle pulse, result valid
result  out  N  x^e mod m, held until next accepted start
mm_count  out  CNT_W  multiplications issued in current/last operation
mm_start  out  1  one-cycle multiplier start pulse
mm_a  out  N  multiplier operand a
mm_b  out  N  multiplier operand b
mm_m  out  N  multiplier modulus (registered in_m)
mm_done  in  1  multiplier completion
mm_result  in  N  multiplier result, valid when mm_done high

Behaviour:
- Reset: state IDLE; busy, done, mm_start = 0; result, mm_a, mm_b, mm_m, mm_count = 0. Reset mid-operation aborts immediately. The multiplier shares reset, so no handshake is owed.
- Start: start in IDLE latches in_x, in_e, in_m, in_r, in_r2 and min(in_elen, E_W) into internal registers. It also sets A <= in_r, idx <= len-1, mm_count <= 0, busy <= 1. start outside IDLE is ignored.
- Internal registers: A (accumulator), XT (Montgomery base), idx (current bit), op-done flag.
- Every multiplication is a two-phase operation:
  - ISSUE phase (1 cycle): mm_a/mm_b hold the operands and mm_start = 1; mm_count increments.
  - WAIT phase: mm_start = 0; mm_a/mm_b/mm_m stay stable; exit on the edge where mm_done = 1, capturing mm_result.
  - mm_done outside WAIT is ignored.
- States and transitions:
  - IDLE -> TOMONT on start.
  - TOMONT: a = in_x, b = R2; XT <= mm_result. Next state is SQ if len > 0, else FROMMONT.
  - SQ: a = b = A; A <= mm_result. Next state is MUL if e[idx] = 1. Otherwise, if idx = 0 go to FROMMONT, else idx-- and return to SQ.
  - MUL: a = A, b = XT; A <= mm_result. Next state is FROMMONT if idx = 0, else idx-- and SQ.
  - FROMMONT: a = A, b = 1; result <= mm_result. Next state is DONE.
  - DONE: done = 1 for one cycle, busy = 1, then IDLE (busy = 0).
- len = 0: result = 1 mod m; only 2 multiplications are issued. Leading-zero exponent bits within len are squared normally; the result is still correct.
- mm_count total = 2 + len + popcount(e[len-1:0]).
- Latency: let L = cycles from the mm_start cycle to the mm_done cycle. Each op costs L+1 cycles, the start edge adds 1, and DONE adds 1. With a fixed L, total cycles from start to done = 2 + mm_count·(L+1).
- mm_m = latched in_m for the whole operation.

Test Plan:
- N=8 (R=256), m=13, r=9, r2=3, x=2, e=5, elen=3, behavioural multiplier with L=4 -> done after 2+7·5 = 37 cycles; result=6; mm_count=7; busy high throughout.
- Same setup, elen=0 (e ignored) -> result=1, mm_count=2, done after 12 cycles.
- x=7, e=0b1011, elen=4, m=13 -> result=7^11 mod 13 = 2, mm_count=9. Exponent bits above elen set to 1 must not change the result.
- start pulsed again mid-operation, and a spurious mm_done injected during an ISSUE cycle and in IDLE -> both ignored; result and mm_count unchanged from the clean run.
- reset asserted during the WAIT of the third multiplication -> next cycle: IDLE, busy=0, mm_start=0, outputs zero. A new start then completes correctly with random L in 1..20.
- N=512 random x, e, odd m against a golden model, elen=512, multiplier L random per op -> result matches golden; mm_a/mm_b stable throughout every WAIT.
